// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings for the receive and transmit
// paths, the default bit period, and a small helper for terminal counts.
package uart_pkg;

   // 27 MHz system clock / 115200 baud
   localparam int DEFAULT_DELAY_FRAMES = 234;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_BIT = 3'd1,
      READ      = 3'd2,
      STOP_BIT  = 3'd3,
      WAIT_HIGH = 3'd4
   } rxState_t;

   // The transmitter reuses the same encoding values so that debug probes
   // read the same on both sides of the link.
   typedef enum logic [2:0] {
      TX_IDLE      = 3'd0,
      TX_START_BIT = 3'd1,
      TX_WRITE     = 3'd2,
      TX_STOP_BIT  = 3'd3,
      TX_DEBOUNCE  = 3'd4
   } txState_t;

   // Last counter value of a period of the given length.
   function automatic logic [15:0] lastCount(input int cycles);
      return 16'(cycles - 1);
   endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte-level handshake between the UART receiver (master) and its consumer
// (slave), plus the one-cycle error pulses.
interface uart_receiver_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;

   modport master (
      output rx_data,
      output rx_valid,
      output frame_err,
      output overrun,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  overrun,
      output rx_ready
   );
endinterface

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset to
// the idle-high level so reset never looks like a start bit.
module uart_bit_sync (
   input  logic clk,
   input  logic rst,
   input  logic asyncIn,
   output logic syncOut
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta    <= 1'b1;
         syncOut <= 1'b1;
      end else begin
         meta    <= asyncIn;
         syncOut <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling FSM, shift register and a one-deep
// holding register with valid/ready handshake, frame error and overrun pulses.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            uart_rx,
   output logic            busy,
   uart_receiver_if.master rxBus
);

   // Valid range is 4..65535 so both terminal counts fit the 16-bit counter.
   localparam int          HALF_DELAY_WAIT = DELAY_FRAMES / 2;
   localparam logic [15:0] BIT_LAST        = lastCount(DELAY_FRAMES);
   localparam logic [15:0] HALF_LAST       = lastCount(HALF_DELAY_WAIT);

   logic        line;
   rxState_t    state;
   rxState_t    nextState;
   logic [15:0] counter;
   logic [2:0]  bitIndex;
   logic [7:0]  shiftReg;
   logic        bitDone;
   logic        halfDone;
   logic        commit;
   logic        frameErrNow;
   logic [7:0]  rxDataReg;
   logic        rxValidReg;
   logic        frameErrReg;
   logic        overrunReg;

   uart_bit_sync syncInst (
      .clk     (clk),
      .rst     (rst),
      .asyncIn (uart_rx),
      .syncOut (line)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next state plus the single-cycle commit and frame-error strobes. The
   // start bit is re-checked at its midpoint so short glitches are rejected.
   always_comb begin
      nextState   = state;
      bitDone     = (counter == BIT_LAST);
      halfDone    = (counter == HALF_LAST);
      commit      = 1'b0;
      frameErrNow = 1'b0;
      case (state)
         IDLE: begin
            if (!line) begin
               nextState = START_BIT;
            end
         end
         START_BIT: begin
            if (halfDone) begin
               nextState = line ? IDLE : READ;
            end
         end
         READ: begin
            if (bitDone && (bitIndex == 3'd7)) begin
               nextState = STOP_BIT;
            end
         end
         STOP_BIT: begin
            if (bitDone) begin
               if (line) begin
                  commit    = 1'b1;
                  nextState = IDLE;
               end else begin
                  frameErrNow = 1'b1;
                  nextState   = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            if (line) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Bit timing and LSB-first shifting; the counter restarts on every
   // terminal count so it never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         counter  <= 16'd0;
         bitIndex <= 3'd0;
         shiftReg <= 8'h00;
      end else begin
         case (state)
            START_BIT: begin
               if (halfDone) begin
                  counter  <= 16'd0;
                  bitIndex <= 3'd0;
               end else begin
                  counter <= counter + 16'd1;
               end
            end
            READ: begin
               if (bitDone) begin
                  counter  <= 16'd0;
                  shiftReg <= {line, shiftReg[7:1]};
                  if (bitIndex != 3'd7) begin
                     bitIndex <= bitIndex + 3'd1;
                  end
               end else begin
                  counter <= counter + 16'd1;
               end
            end
            STOP_BIT: begin
               if (bitDone) begin
                  counter <= 16'd0;
               end else begin
                  counter <= counter + 16'd1;
               end
            end
            default: counter <= 16'd0;
         endcase
      end
   end

   // Holding register: a commit always wins over a same-cycle handshake, and
   // overwriting an unconsumed byte that is not being taken flags an overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxDataReg   <= 8'h00;
         rxValidReg  <= 1'b0;
         frameErrReg <= 1'b0;
         overrunReg  <= 1'b0;
      end else begin
         frameErrReg <= frameErrNow;
         overrunReg  <= commit && rxValidReg && !rxBus.rx_ready;
         if (commit) begin
            rxDataReg  <= shiftReg;
            rxValidReg <= 1'b1;
         end else if (rxValidReg && rxBus.rx_ready) begin
            rxValidReg <= 1'b0;
         end
      end
   end

   assign rxBus.rx_data   = rxDataReg;
   assign rxBus.rx_valid  = rxValidReg;
   assign rxBus.frame_err = frameErrReg;
   assign rxBus.overrun   = overrunReg;
   assign busy            = (state != IDLE);

endmodule
